// File: rtl/cache_types.sv
// Shared widths, FSM state encoding and line type for the L1 data/instruction cache.
package cache_types;

  localparam int S_INDEX  = 4;
  localparam int S_OFFSET = 5;
  localparam int S_TAG    = 32 - S_INDEX - S_OFFSET;
  localparam int S_LINE   = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  typedef logic [S_LINE-1:0] cache_line_t;

endpackage

// File: rtl/cache_data_array.sv
// Flop-based line storage: asynchronous read, byte-lane CPU writes and full-line fills.
module cache_data_array #(
  parameter int S_INDEX = 4,
  parameter int S_LINE  = 256,
  parameter int WORD_W  = 3
) (
  input  logic              clk,
  input  logic [S_INDEX-1:0] i_index,
  input  logic [WORD_W-1:0]  i_word,
  input  logic              i_we_word,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_byte_en,
  input  logic              i_we_line,
  input  logic [S_LINE-1:0] i_line,
  output logic [S_LINE-1:0] o_line
);

  logic [S_LINE-1:0] r_data [2**S_INDEX];

  assign o_line = r_data[i_index];

  // Line fill takes priority; otherwise merge enabled byte lanes into the addressed word.
  always_ff @(posedge clk) begin
    if (i_we_line) begin
      r_data[i_index] <= i_line;
    end else if (i_we_word) begin
      for (int b = 0; b < 4; b++) begin
        if (i_byte_en[b]) begin
          r_data[i_index][{i_word, 2'(b), 3'd0} +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with a three-state miss FSM.
module data_cache #(
  parameter int S_INDEX  = 4,
  parameter int S_OFFSET = 5,
  parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_byte_enable,
  output logic         mem_resp,
  output logic [31:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  import cache_types::*;

  localparam int SETS   = 2 ** S_INDEX;
  localparam int WORD_W = S_OFFSET - 2;

  logic [S_TAG-1:0]   w_tag;
  logic [S_INDEX-1:0] w_index;
  logic [WORD_W-1:0]  w_word;
  logic               w_unused_addr_lo;
  logic               w_req;
  logic               w_hit;
  cache_line_t        w_line;

  logic               w_we_word;
  logic               w_we_line;
  logic               w_set_dirty;
  logic               w_clr_dirty;

  cache_state_t       r_state;
  cache_state_t       w_next;
  logic [SETS-1:0]    r_valid;
  logic [SETS-1:0]    r_dirty;
  logic [S_TAG-1:0]   r_tag [SETS];

  assign w_tag            = mem_address[31:S_OFFSET+S_INDEX];
  assign w_index          = mem_address[S_OFFSET+S_INDEX-1:S_OFFSET];
  assign w_word           = mem_address[S_OFFSET-1:2];
  assign w_unused_addr_lo = ^mem_address[1:0];
  assign w_req            = mem_read | mem_write;
  assign w_hit            = r_valid[w_index] && (r_tag[w_index] == w_tag);

  cache_data_array #(
    .S_INDEX(S_INDEX),
    .S_LINE (S_LINE),
    .WORD_W (WORD_W)
  ) u_data (
    .clk      (clk),
    .i_index  (w_index),
    .i_word   (w_word),
    .i_we_word(w_we_word),
    .i_wdata  (mem_wdata),
    .i_byte_en(mem_byte_enable),
    .i_we_line(w_we_line),
    .i_line   (pmem_rdata),
    .o_line   (w_line)
  );

  // Next-state and all outputs; a write wins when read and write are both raised.
  always_comb begin
    w_next       = r_state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    w_we_word    = 1'b0;
    w_we_line    = 1'b0;
    w_set_dirty  = 1'b0;
    w_clr_dirty  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            mem_resp = 1'b1;
            if (mem_write) begin
              w_we_word   = 1'b1;
              w_set_dirty = 1'b1;
            end else begin
              mem_rdata = w_line[{w_word, 5'd0} +: 32];
            end
          end else if (r_valid[w_index] && r_dirty[w_index]) begin
            w_next = WRITEBACK;
          end else begin
            w_next = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[w_index], w_index, {S_OFFSET{1'b0}}};
        pmem_wdata   = w_line;
        if (pmem_resp) begin
          w_clr_dirty = 1'b1;
          w_next      = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {w_tag, w_index, {S_OFFSET{1'b0}}};
        if (pmem_resp) begin
          w_we_line = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State register; reset abandons any line transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Valid/dirty bookkeeping: fills install a clean line, write hits mark it dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_we_line) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_set_dirty) begin
      r_dirty[w_index] <= 1'b1;
    end else if (w_clr_dirty) begin
      r_dirty[w_index] <= 1'b0;
    end
  end

  // Tag store is not reset; valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (w_we_line) begin
      r_tag[w_index] <= w_tag;
    end
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate L1 cache that answers the CPU pipeline's instruction or data memory requests. The CPU side has read, write, address, wdata, byte-enable, resp and rdata. The memory side issues whole-line reads and writebacks to physical memory. One instance serves the instruction port and one serves the data port; the instruction instance never sees writes.

## Interface
Parameters:
- S_INDEX, 4, set-index bits (16 sets)
- S_OFFSET, 5, line-offset bits (32-byte / 256-bit lines)
- S_TAG, 32-S_INDEX-S_OFFSET, tag bits

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- mem_read  in  1  CPU read request, level
- mem_write  in  1  CPU write request, level
- mem_address  in  32  CPU byte address, word-aligned (bits [1:0] ignored)
- mem_wdata  in  32  write data, already lane-shifted by the requestor
- mem_byte_enable  in  4  write byte mask for the addressed word
- mem_resp  out  1  request complete this cycle
- mem_rdata  out  32  addressed word; valid when mem_resp=1 on a read
- pmem_read  out  1  line fill request, level
- pmem_write  out  1  line writeback request, level
- pmem_address  out  32  line address, bits [S_OFFSET-1:0]=0
- pmem_wdata  out  256  victim line
- pmem_rdata  in  256  fill line; valid when pmem_resp=1
- pmem_resp  in  1  pmem transfer done, single-cycle pulse

## Operation
- Address split: tag = addr[31:S_OFFSET+S_INDEX], index = addr[S_OFFSET+S_INDEX-1:S_OFFSET], word = addr[S_OFFSET-1:2].
- Per set: valid bit, dirty bit, tag and 256-bit line. Arrays are flop-based with asynchronous read.
- Request handshake:
  - The requestor holds read/write, address, wdata and byte_enable stable until it samples mem_resp=1.
  - mem_read and mem_write are never both asserted. If both are asserted, the cache treats the request as a write.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - hit = valid[index] && tag match.
  - Read hit: mem_resp=1 combinationally, mem_rdata = line[word*32 +: 32].
  - Write hit: mem_resp=1. On the clock edge, write byte lanes enabled by mem_byte_enable into line[word] and set dirty[index].
  - Miss with valid && dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
  - No request: stay in IDLE, all outputs 0.
- WRITEBACK:
  - pmem_write=1, pmem_address = {stored tag, index, 0}, pmem_wdata = stored line.
  - On pmem_resp: clear dirty[index], go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address = {addr tag, index, 0}.
  - On pmem_resp: load line from pmem_rdata, set tag, valid=1, dirty=0, go to IDLE.
  - Back in IDLE the held request now hits and completes.
- mem_resp is asserted only in IDLE on a hit. It is never asserted in WRITEBACK or ALLOCATE.
- pmem_read and pmem_write are never both 1.

## Timing
- Reset: state=IDLE, all valid=0, all dirty=0. All outputs 0 in the cycle after the reset edge; data and tag arrays are not cleared.
- Reset mid-miss: the transfer is abandoned and pmem_read/pmem_write deassert in the next cycle. A pmem_resp that arrives later is ignored in IDLE.
- Hit latency: resp in the same cycle the request is presented (zero wait states).
- Clean miss: resp in cycle 1 + L after request, where L = pmem latency to pmem_resp inclusive.
- Dirty miss: resp in cycle 1 + L_wb + L_fill.
- Back-to-back hits: one completes per cycle. A new request presented the cycle after mem_resp is evaluated fresh.
- A write hit's update is visible to a read of the same word in the next cycle.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.

## Structure
- Package cache_types:
  - Width constants S_INDEX, S_OFFSET, S_TAG, S_LINE=256.
  - cache_state_t enum {IDLE, WRITEBACK, ALLOCATE}.
  - cache_line_t.
- Sub-module cache_data_array:
  - 2^S_INDEX × 256-bit storage, asynchronous read.
  - 32-bit byte-enable write for CPU writes, full-line write for fills.
- Valid, dirty and tag arrays plus the FSM live in data_cache.

## Test plan
- Cold read 0x0000_0104 with pmem L=3, returning a fill line with word1=0xDEADBEEF:
  - pmem_read=1, pmem_address=0x0000_0100.
  - mem_resp in cycle 4 with mem_rdata=0xDEADBEEF.
  - Re-read of the same address hits in cycle 0.
- Write 0xAABBCCDD, mbe=4'b0110 to 0x0000_0104 (hit, prior word 0xDEADBEEF):
  - resp same cycle.
  - Next read returns 0xDEBBCCEF.
- Dirty conflict read 0x0000_0904 (same index 8 as 0x104, different tag):
  - pmem_write with pmem_address=0x0000_0100 and the modified line.
  - Then pmem_read with pmem_address=0x0000_0900.
  - resp at 1+L_wb+L_fill.
- Clean conflict after the writeback (read 0x0000_0104 again):
  - No pmem_write, only pmem_read.
- Assert rst while in ALLOCATE:
  - pmem_read=0 in the next cycle.
  - Late pmem_resp produces no resp.
  - The previously cached address misses.
- Sweep reads over all 16 indices then re-read all:
  - 16 misses, then 16 zero-latency hits.
  - pmem_read and pmem_write never both 1 (assertion).
